fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 8, FIFO word width.
REQ-002 Parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-003 Parameter MAX_BURST, default 4, maximum words one requester may write per grant (1..16).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  NUM_REQ  per-requester valid; req[i] with req_data[i] stable until gnt[i].
REQ-007 req_data  input  NUM_REQ x DATA_WIDTH  per-requester write word.
REQ-008 fifo_full  input  1  FIFO write-side full flag.
REQ-009 fifo_almost_full  input  1  FIFO write-side almost-full flag.
REQ-010 gnt  output  NUM_REQ  one-hot single-cycle pulse: word of requester i accepted this cycle.
REQ-011 wr_en  output  1  registered FIFO write enable.
REQ-012 din  output  DATA_WIDTH  registered FIFO write data.
REQ-013 owner  output  clog2(NUM_REQ)  index of current grant holder.

Function
REQ-014 FSM states IDLE, BURST, STALL; encoding in the package.
REQ-015 IDLE: any req set -> BURST with owner = first set req at or after rr_ptr (round-robin); else stay.
REQ-016 BURST: accept when req[owner] & !fifo_full & !fifo_almost_full; gnt[owner]=1 combinationally that cycle.
REQ-017 Accepted word appears on din with wr_en=1 exactly one cycle after gnt (latency 1); wr_en=0 otherwise.
REQ-018 BURST -> STALL when req[owner] & (fifo_full | fifo_almost_full); burst counter held.
REQ-019 STALL -> BURST when !fifo_full & !fifo_almost_full; owner unchanged; no gnt while in STALL.
REQ-020 Burst ends when accepted count reaches MAX_BURST or req[owner] is low in BURST; then rr_ptr = owner+1 mod NUM_REQ, burst counter cleared, -> IDLE.
REQ-021 IDLE costs one cycle between bursts; no requester may be starved beyond NUM_REQ-1 intervening bursts.
REQ-022 gnt is at most one-hot; never asserted in IDLE or STALL.
REQ-023 fifo_full and fifo_almost_full both high is treated as full (stall); neither ever causes a dropped or duplicated word.
REQ-024 Deasserting req[owner] during STALL ends the burst on the next cycle (-> IDLE), no gnt issued.

Reset
REQ-025 rst high at a clock edge: state=IDLE, rr_ptr=0, owner=0, burst counter=0, wr_en=0, din=0, gnt=0.
REQ-026 Reset mid-burst discards the in-flight registered word (wr_en=0 on the cycle after reset edge).

Configuration
REQ-027 Macro FIFO_WR_ARB_STATS_EN: when defined, adds outputs wr_cnt (16 bit, words written) and stall_cnt (16 bit, cycles in STALL), both saturating at 16'hFFFF, cleared by rst.
REQ-028 When undefined, those ports and counters do not exist; all other behaviour identical.

Structure
REQ-029 Package fifo_wr_arb_pkg holds the state enum typedef, and the counter width constant STAT_W=16.
REQ-030 Round-robin select is one sub-module rr_pick (req vector + pointer -> index, found flag), purely combinational.

Verification
REQ-031 Single req[0], 3 words 8'h11,8'h22,8'h33, FIFO empty -> gnt[0] three consecutive cycles; wr_en/din 11,22,33 one cycle later each; IDLE after.
REQ-032 req[0..3] all held, MAX_BURST=4 -> bursts of 4 in order owner 0,1,2,3,0; one IDLE cycle between bursts.
REQ-033 fifo_almost_full raised after 2nd word of a burst for 5 cycles -> no gnt for 5 cycles, then words 3-4 resume under same owner.
REQ-034 req[2] dropped after 1 word -> burst ends, next grant to requester 3, rr_ptr=3.
REQ-035 rst pulsed mid-burst -> all outputs zero next cycle, next grant starts from requester 0.
REQ-036 With FIFO_WR_ARB_STATS_EN, 10 writes and 5 stall cycles -> wr_cnt=10, stall_cnt=5.

Source files
------------

// File: rtl/fifo_wr_arb_pkg.sv
// ------------------------------------------------------------------
// fifo_wr_arb_pkg : shared types and constants for fifo_wr_arb
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package fifo_wr_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   localparam int STAT_W = 16;

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arb_rr_pick.sv
// ------------------------------------------------------------------
// rr_pick : first set request at or after a pointer, combinational
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_pick
   import fifo_wr_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [$clog2(NUM_REQ)-1:0] idx_o,
   output logic                       found_o
);

   localparam int IW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] w_rot;
   logic [IW:0]        w_ofs;
   logic [IW:0]        w_sum;

   // Rotate so the pointer position lands on bit 0, then take the lowest set bit.
   always_comb begin
      w_rot = NUM_REQ'({req_i, req_i} >> ptr_i);
      w_ofs = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_ofs = (IW+1)'(k);
         end
      end
      w_sum = {1'b0, ptr_i} + w_ofs;
      if (w_sum >= (IW+1)'(NUM_REQ)) begin
         w_sum = w_sum - (IW+1)'(NUM_REQ);
      end
      idx_o   = w_sum[IW-1:0];
      found_o = |req_i;
   end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arb.sv
// ------------------------------------------------------------------
// fifo_wr_arb : round-robin burst arbiter driving a FIFO write port
// Optional counters via FIFO_WR_ARB_STATS_EN.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fifo_wr_arb
   import fifo_wr_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
   input  logic                                fifo_full,
   input  logic                                fifo_almost_full,
   output logic [NUM_REQ-1:0]                  gnt,
   output logic                                wr_en,
   output logic [DATA_WIDTH-1:0]               din,
   output logic [$clog2(NUM_REQ)-1:0]          owner
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0]                   wr_cnt,
   output logic [STAT_W-1:0]                   stall_cnt
`endif
);

   localparam int OW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   state_t               state_q, state_d;
   logic [OW-1:0]        owner_q, owner_d;
   logic [OW-1:0]        ptr_q, ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 wr_en_q;
   logic [DATA_WIDTH-1:0] din_q;

   logic [OW-1:0]        w_pick_idx;
   logic                 w_pick_found;
   logic                 w_full;
   logic                 w_take;
   logic                 w_accept;
   logic                 w_end;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .idx_o   (w_pick_idx),
      .found_o (w_pick_found)
   );

   assign w_full = fifo_full | fifo_almost_full;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      w_take  = 1'b0;
      w_end   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_pick_found) begin
               state_d = ST_BURST;
               owner_d = w_pick_idx;
               cnt_d   = '0;
            end
         end
         ST_BURST: begin
            if (!req[owner_q]) begin
               w_end = 1'b1;
            end else if (w_full) begin
               state_d = ST_STALL;
            end else begin
               w_take = 1'b1;
               cnt_d  = cnt_q + CW'(1);
               if (cnt_q + CW'(1) == CW'(MAX_BURST)) begin
                  w_end = 1'b1;
               end
            end
         end
         ST_STALL: begin
            if (!req[owner_q]) begin
               w_end = 1'b1;
            end else if (!w_full) begin
               state_d = ST_BURST;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (w_end) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         ptr_d   = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);
      end
   end

   // No grant while reset is high: the word would be consumed and then discarded.
   assign w_accept = w_take & ~rst;

   always_comb begin
      gnt = '0;
      if (w_accept) begin
         gnt[owner_q] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         wr_en_q <= 1'b0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         wr_en_q <= w_accept;
         if (w_accept) begin
            din_q <= req_data[owner_q];
         end
      end
   end

   assign wr_en = wr_en_q;
   assign din   = din_q;
   assign owner = owner_q;

`ifdef FIFO_WR_ARB_STATS_EN
   logic [STAT_W-1:0] wr_cnt_q;
   logic [STAT_W-1:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (wr_en_q && (wr_cnt_q != '1)) begin
            wr_cnt_q <= wr_cnt_q + STAT_W'(1);
         end
         if ((state_q == ST_STALL) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STAT_W'(1);
         end
      end
   end

   assign wr_cnt    = wr_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
// ------------------------------------------------------------------
// tb_fifo_wr_arb : directed + random bench for fifo_wr_arb
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_fifo_wr_arb;

   localparam int DW = 8;
   localparam int N  = 4;
   localparam int MB = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N-1:0]          req;
   logic [N-1:0][DW-1:0]  req_data;
   logic                  ff, af;
   logic [N-1:0]          gnt;
   logic                  wr_en;
   logic [DW-1:0]         din;
   logic [1:0]            owner;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0]           wr_cnt, stall_cnt;
`endif

   always #5 clk = ~clk;

   fifo_wr_arb #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
      .clk              (clk),
      .rst              (rst),
      .req              (req),
      .req_data         (req_data),
      .fifo_full        (ff),
      .fifo_almost_full (af),
      .gnt              (gnt),
      .wr_en            (wr_en),
      .din              (din),
      .owner            (owner)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .wr_cnt           (wr_cnt),
      .stall_cnt        (stall_cnt)
`endif
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Each requester holds a queue of words; its head is presented until granted.
   logic [DW-1:0] wq[N][$];

   // Reference: an open burst (who, how many words so far, paused or not).
   bit            m_busy, m_held, m_wr;
   int            m_own, m_words, m_ptr;
   logic [DW-1:0] m_din;
   int            m_wr_total, m_stall_total;

   int            blog[$];
   logic [N-1:0]  last_gnt = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         req[i]      = (wq[i].size() != 0);
         req_data[i] = (wq[i].size() != 0) ? wq[i][0] : '0;
      end
   endtask

   function automatic logic [N-1:0] exp_gnt();
      logic [N-1:0] g = '0;
      if (!rst && m_busy && !m_held && req[m_own] && !(ff | af)) g[m_own] = 1'b1;
      return g;
   endfunction

   task automatic close_burst();
      m_busy  = 1'b0;
      m_held  = 1'b0;
      m_words = 0;
      m_ptr   = (m_own + 1) % N;
   endtask

   task automatic model_update();
      if (rst) begin
         m_busy = 0; m_held = 0; m_wr = 0; m_own = 0; m_words = 0; m_ptr = 0;
         m_din = '0; m_wr_total = 0; m_stall_total = 0;
         return;
      end
      if (m_busy && m_held) m_stall_total++;
      if (m_wr) m_wr_total++;
      m_wr = 1'b0;
      if (!m_busy) begin
         for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) begin
               m_own   = (m_ptr + k) % N;
               m_busy  = 1'b1;
               m_words = 0;
               break;
            end
         end
      end else if (!req[m_own]) begin
         close_burst();
      end else if (m_held) begin
         if (!(ff | af)) m_held = 1'b0;
      end else if (ff | af) begin
         m_held = 1'b1;
      end else begin
         m_wr  = 1'b1;
         m_din = wq[m_own].pop_front();
         m_words++;
         if (m_words == MB) close_burst();
      end
   endtask

   // Called at a negedge; checks, crosses one rising edge, returns at the next negedge.
   task automatic cycle();
      logic [N-1:0] g;
      drive_inputs();
      #1;
      g = exp_gnt();
      check("gnt", gnt, g);
      check("wr_en", wr_en, m_wr);
      if (m_wr) check("din", din, m_din);
      check("owner", owner, m_own);
      if (gnt != 0 && last_gnt == 0) blog.push_back(int'(owner));
      last_gnt = gnt;
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic reset_cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < N; i++) if (wq[i].size() != 0) return 0;
      return 1;
   endfunction

   task automatic run_until_words(input int w);
      int t = 0;
      while (m_words != w && t < 50) begin cycle(); t++; end
      if (m_words != w) begin
         n_fail++;
         $error("FAIL timeout waiting for %0d words: observed %0d", w, m_words);
      end
   endtask

   initial begin
      int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int t;
      rst = 1'b1; ff = 1'b0; af = 1'b0; req = '0; req_data = '0;
      m_busy = 0; m_held = 0; m_wr = 0; m_own = 0; m_words = 0; m_ptr = 0;
      m_din = '0; m_wr_total = 0; m_stall_total = 0;
      @(posedge clk);
      @(negedge clk);
      check("rst_din", din, 0);
      reset_cycle();

      // single requester, three words
      wq[0].push_back(8'h11); wq[0].push_back(8'h22); wq[0].push_back(8'h33);
      repeat (8) cycle();

      // all four requesters saturated: bursts of four, strict rotation from 0
      reset_cycle();
      blog.delete();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 8; k++) wq[i].push_back(DW'(i * 16 + k));
      t = 0;
      while ((!all_empty() || m_busy) && t < 100) begin cycle(); t++; end
      repeat (2) cycle();
      check("burst_count", blog.size(), 8);
      for (int i = 0; i < 8 && i < blog.size(); i++) check("burst_order", blog[i], exp_order[i]);

      // almost-full pause after the second word of a burst
      for (int k = 0; k < 4; k++) wq[1].push_back(DW'(8'hA0 + k));
      run_until_words(2);
      af = 1'b1;
      repeat (5) cycle();
      af = 1'b0;
      repeat (6) cycle();

      // requester 2 leaves after one word; requester 3 is served next
      wq[2].push_back(8'h5A);
      wq[3].push_back(8'h3C); wq[3].push_back(8'h3D);
      repeat (10) cycle();
      check("rr_after_drop", owner, 3);

      // request withdrawn while stalled: burst closes with no grant
      ff = 1'b1;
      for (int k = 0; k < 3; k++) wq[0].push_back(DW'(8'hC0 + k));
      repeat (3) cycle();
      wq[0].delete();
      cycle();
      ff = 1'b0;
      repeat (2) cycle();

      // reset in the middle of a burst
      for (int k = 0; k < 4; k++) wq[1].push_back(DW'(8'hD0 + k));
      run_until_words(2);
      wq[0].push_back(8'hE0); wq[0].push_back(8'hE1);
      reset_cycle();
      #1;
      check("post_rst_wr_en", wr_en, 0);
      check("post_rst_owner", owner, 0);
      check("post_rst_gnt", gnt, 0);
      blog.delete();
      repeat (12) cycle();
      check("post_rst_first", (blog.size() > 0) ? blog[0] : -1, 0);

      // random traffic with random back-pressure
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (wq[i].size() == 0 && $urandom_range(0, 7) == 0) begin
               int n = $urandom_range(1, 6);
               for (int k = 0; k < n; k++) wq[i].push_back(DW'($urandom));
            end
         end
         ff = ($urandom_range(0, 9) == 0);
         af = ($urandom_range(0, 5) == 0);
         cycle();
      end
      ff = 1'b0; af = 1'b0;
      for (int i = 0; i < N; i++) wq[i].delete();
      repeat (4) cycle();

`ifdef FIFO_WR_ARB_STATS_EN
      // ten writes, five stall cycles
      reset_cycle();
      for (int k = 0; k < 10; k++) wq[0].push_back(DW'(k));
      run_until_words(2);
      af = 1'b1;
      repeat (5) cycle();
      af = 1'b0;
      t = 0;
      while ((!all_empty() || m_busy) && t < 60) begin cycle(); t++; end
      repeat (3) cycle();
      check("wr_cnt", wr_cnt, 10);
      check("stall_cnt", stall_cnt, 5);
      check("wr_cnt_model", wr_cnt, m_wr_total);
      check("stall_cnt_model", stall_cnt, m_stall_total);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
